img_op_scheduler: RTL and testbench

//  Queues image-operation commands (mirror, grayscale, sharpen) from the host/testbench side.

---
 rtl/img_op_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_img_op_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_op_scheduler.sv
// rtl/img_op_scheduler.sv - image-operation command queue, engine issue FSM and watchdog (optional stats: IMG_SCHED_STATS_EN)
module img_op_scheduler #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_op,
    output logic                       cmd_ready,
    output logic                       cmd_rejected,
    output logic                       eng_start,
    output logic [1:0]                 eng_op,
    input  logic                       mirror_done,
    input  logic                       gray_done,
    input  logic                       filter_done,
    output logic                       busy,
    output logic                       op_done,
    output logic [1:0]                 op_done_id,
    output logic                       timeout_err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [15:0]                done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FINISH,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      cur_op;
    logic [WW-1:0]   watchdog;
    logic            full;
    logic            push;
    logic            pop;
    logic            match;

    assign full = (count == CW'(DEPTH));
    // Reserved op 3 never occupies a slot; it only produces a reject pulse.
    assign push = cmd_valid && !full && (cmd_op != 2'd3);
    // Only IDLE pops, so ERR naturally blocks issue while still accepting pushes.
    assign pop  = (state == S_IDLE) && (count != '0);

    // Each op has its own done flag; flags belonging to other ops are ignored.
    always_comb begin
        match = 1'b0;
        case (cur_op)
            2'd0:    match = mirror_done;
            2'd1:    match = gray_done;
            2'd2:    match = filter_done;
            default: match = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered reject pulse for a reserved op that would otherwise have been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rejected <= 1'b0;
        end else begin
            cmd_rejected <= cmd_valid && !full && (cmd_op == 2'd3);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a done match beats watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (count != '0) state_next = S_START;
            S_START:  state_next = S_WAIT;
            S_WAIT: begin
                if (match) begin
                    state_next = S_FINISH;
                end else if (watchdog == WD_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_FINISH: state_next = S_IDLE;
            S_ERR:    if (err_clr) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Current op captured at pop; held until the next pop so eng_op stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_op <= 2'd0;
        end else if (pop) begin
            cur_op <= mem[rd_ptr];
        end
    end

    // Watchdog: cleared at issue, counts every WAIT cycle, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            watchdog <= '0;
        end else if (state == S_START) begin
            watchdog <= '0;
        end else if ((state == S_WAIT) && (watchdog != WD_MAX)) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    // Sticky timeout flag: set on entry to ERR, cleared only by err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if ((state == S_WAIT) && (state_next == S_ERR)) begin
            timeout_err <= 1'b1;
        end else if ((state == S_ERR) && err_clr) begin
            timeout_err <= 1'b0;
        end
    end

`ifdef IMG_SCHED_STATS_EN
    // Completed-op counter, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= 16'd0;
        end else if (state == S_FINISH) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
`else
    assign done_cnt = 16'd0;
`endif

    assign cmd_ready   = !full;
    assign queue_count = count;
    assign eng_start   = (state == S_START);
    assign eng_op      = cur_op;
    assign busy        = (state != S_IDLE);
    assign op_done     = (state == S_FINISH);
    assign op_done_id  = (state == S_FINISH) ? cur_op : 2'd0;

endmodule

// File: tb/tb_img_op_scheduler.sv
// tb/tb_img_op_scheduler.sv - self-checking bench for img_op_scheduler
module tb_img_op_scheduler;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        cmd_rejected;
    logic        eng_start;
    logic [1:0]  eng_op;
    logic        mirror_done;
    logic        gray_done;
    logic        filter_done;
    logic        busy;
    logic        op_done;
    logic [1:0]  op_done_id;
    logic        timeout_err;
    logic        err_clr;
    logic [2:0]  queue_count;
    logic [15:0] done_cnt;

    int tests = 0;
    int fails = 0;
    int starts_seen = 0;
    int dones_seen = 0;
    int model_cnt = 0;
    int model_q[$];

    img_op_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .cmd_rejected(cmd_rejected),
        .eng_start(eng_start), .eng_op(eng_op),
        .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
        .busy(busy), .op_done(op_done), .op_done_id(op_done_id),
        .timeout_err(timeout_err), .err_clr(err_clr),
        .queue_count(queue_count), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Event monitor: counts issued starts and completions seen by the bench.
    always @(posedge clk) begin
        if (eng_start === 1'b1) starts_seen <= starts_seen + 1;
        if (op_done === 1'b1)   dones_seen  <= dones_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef IMG_SCHED_STATS_EN
        return 16'(model_cnt);
`else
        return 16'd0;
`endif
    endfunction

    task automatic push(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        if (op != 2'd3 && model_q.size() < DEPTH) model_q.push_back(int'(op));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (eng_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, eng_start, 1);
    endtask

    // Called d posedges before the matching flag is raised; wrong flags held high meanwhile.
    task automatic respond(input logic [1:0] op, input int d);
        mirror_done = (op != 2'd0);
        gray_done   = (op != 2'd1);
        filter_done = (op != 2'd2);
        repeat (d) @(posedge clk);
        #1;
        mirror_done = 1'b1;
        gray_done   = 1'b1;
        filter_done = 1'b1;
        tick();
        mirror_done = 1'b0;
        gray_done   = 1'b0;
        filter_done = 1'b0;
        model_cnt++;
        check("op_done", op_done, 1);
        check("op_done_id", op_done_id, op);
        check("eng_op_held", eng_op, op);
        check("no_timeout", timeout_err, 0);
        check("done_cnt", done_cnt, exp_cnt());
        tick();
        check("op_done_pulse", op_done, 0);
        check("idle_after", busy, 0);
    endtask

    // In a START cycle: compare issue against the model queue, then complete it.
    task automatic serve(input int d);
        int exp_op;
        exp_op = model_q.pop_front();
        check("issue_op", eng_op, exp_op);
        check("issue_qcount", queue_count, model_q.size());
        respond(2'(exp_op), d);
    endtask

    initial begin
        int inflight;
        int s_before;
        int d_before;
        int n;
        logic [1:0] op;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; err_clr = 1'b0;
        mirror_done = 1'b0; gray_done = 1'b0; filter_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_qcount", queue_count, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_op", eng_op, 0);
        check("rst_op_done", op_done, 0);
        check("rst_op_done_id", op_done_id, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_rejected", cmd_rejected, 0);
        check("rst_done_cnt", done_cnt, 0);

        // Single op with start latency check.
        push(2'd1);
        check("lat_qcount", queue_count, 1);
        check("lat_no_start_yet", eng_start, 0);
        tick();
        check("lat_start", eng_start, 1);
        check("lat_busy", busy, 1);
        serve(10);

        // Random single ops, delays up to the watchdog boundary.
        repeat (6) begin
            push(2'($urandom_range(0, 2)));
            wait_start("rand_start");
            serve($urandom_range(1, TOUT));
        end
        push(2'($urandom_range(0, 2)));
        wait_start("edge_start");
        serve(TOUT);

        // Fill FIFO while engine holds one op, then try a fifth push.
        push(2'($urandom_range(0, 2)));
        wait_start("fill_start");
        inflight = model_q.pop_front();
        check("fill_inflight_op", eng_op, inflight);
        for (int i = 0; i < DEPTH; i++) push(2'($urandom_range(0, 2)));
        check("full_qcount", queue_count, DEPTH);
        check("full_ready", cmd_ready, (model_q.size() < DEPTH) ? 1 : 0);
        push(2'($urandom_range(0, 3)));
        check("full_qcount_after", queue_count, model_q.size());
        check("full_no_reject", cmd_rejected, 0);
        respond(2'(inflight), 1);
        for (int i = 0; i < DEPTH; i++) begin
            wait_start("drain_start");
            serve($urandom_range(1, 8));
        end

        // Watchdog expiry with only a wrong done flag.
        op = 2'($urandom_range(0, 2));
        push(op);
        wait_start("to_start");
        inflight = model_q.pop_front();
        s_before = starts_seen;
        d_before = dones_seen;
        mirror_done = (op != 2'd0);
        gray_done   = (op == 2'd0);
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        mirror_done = 1'b0;
        gray_done   = 1'b0;
        check("to_wait_cycles", n, TOUT + 1);
        check("to_busy", busy, 1);
        push(2'($urandom_range(0, 2)));
        check("err_accepts_push", queue_count, 1);
        repeat (3) tick();
        check("err_no_issue", starts_seen, s_before + 1);
        check("err_no_done", dones_seen, d_before);
        check("err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_timeout", timeout_err, 0);
        check("clr_idle", busy, 0);
        wait_start("after_clr_start");
        serve($urandom_range(1, 14));

        // Reserved op is rejected.
        s_before = starts_seen;
        push(2'd3);
        check("rej_pulse", cmd_rejected, 1);
        check("rej_qcount", queue_count, 0);
        tick();
        check("rej_pulse_end", cmd_rejected, 0);
        repeat (3) tick();
        check("rej_no_start", starts_seen, s_before);

        // Reset during WAIT with two queued ops.
        op = 2'($urandom_range(0, 2));
        push(op);
        wait_start("rst_mid_start");
        push(2'($urandom_range(0, 2)));
        push(2'($urandom_range(0, 2)));
        check("rst_mid_qcount_pre", queue_count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        model_cnt = 0;
        check("rstm_busy", busy, 0);
        check("rstm_qcount", queue_count, 0);
        check("rstm_eng_start", eng_start, 0);
        check("rstm_timeout", timeout_err, 0);
        check("rstm_ready", cmd_ready, 1);
        check("rstm_done_cnt", done_cnt, 0);
        s_before = starts_seen;
        d_before = dones_seen;
        mirror_done = 1'b1; gray_done = 1'b1; filter_done = 1'b1;
        tick();
        mirror_done = 1'b0; gray_done = 1'b0; filter_done = 1'b0;
        repeat (4) tick();
        check("rstm_no_done", dones_seen, d_before);
        check("rstm_no_start", starts_seen, s_before);

        // Three completions after reset for the statistics counter.
        repeat (3) begin
            push(2'($urandom_range(0, 2)));
            wait_start("stat_start");
            serve($urandom_range(1, 6));
        end
        check("stat_done_cnt", done_cnt, exp_cnt());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
